uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (start/data/busy interface) between NUM_REQ byte-stream requesters.
- Uses round-robin arbitration with burst ownership: a granted requester keeps the transmitter until it flags its last byte, drops its request, or hits MAX_BURST.
- Sits between command/status producers and the single uart_tx instance on the board link.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART link constants and arbiter state encodings
// Imported by uart_tx_arbiter; the baud constants are common with uart_rx/uart_tx.
package uart_pkg;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 115_200;
  localparam int BIT_CLK = CLK_HZ / BAUD;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
// Ports:
//   req - request vector (N bits)
//   ptr - index of the last winner; scanning starts at ptr+1 with wrap
//   idx - index of the selected request (0 when none is set)
//   any - high when at least one request bit is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Walk from the farthest candidate back towards ptr+1 so the nearest set bit is written last.
    for (int k = N; k >= 1; k--) begin
      if (req[IW'((int'(ptr) + k) % N)]) begin
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter sharing one UART transmitter
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   req/req_data/req_last  - per-requester byte flag, byte (8 bits each), last-of-burst marker
//   ack                    - one-cycle consume pulse to the owning requester, coincident with tx_start
//   owner, owner_valid     - current grant holder and grant-held flag
//   tx_start, tx_data      - start pulse and registered byte to the transmitter
//   tx_busy                - transmitter busy
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int BUSY_WAIT = 4,
  localparam int OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic [OW-1:0]        owner,
  output logic                 owner_valid,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);

  arb_state_t          state, state_n;
  logic [OW-1:0]       rr_ptr;
  logic [OW-1:0]       pick_idx;
  logic                pick_any;
  logic [7:0]          burst_cnt;
  logic [3:0]          wait_cnt;
  logic                last_flag;
  logic                do_grant, do_load, do_release, wait_inc;
  logic [7:0]          data_arr [NUM_REQ];
  logic [7:0]          cur_data;
  logic [NUM_REQ-1:0]  ack_onehot;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[8*i+7 : 8*i];
  end

  assign cur_data   = data_arr[owner];
  assign ack_onehot = NUM_REQ'(1) << owner;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    do_grant   = 1'b0;
    do_load    = 1'b0;
    do_release = 1'b0;
    wait_inc   = 1'b0;
    case (state)
      IDLE: begin
        // A frame still on the line (e.g. left over from before a reset) blocks new grants.
        if (pick_any && !tx_busy) begin
          do_grant = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        do_load = 1'b1;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A transmitter that never raises busy (or finishes inside the window) still releases us.
        if (tx_busy || (wait_cnt + 4'd1 == 4'(BUSY_WAIT))) begin
          state_n = WAIT_DONE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (req[owner] && !last_flag && (burst_cnt < 8'(MAX_BURST))) begin
            state_n = LOAD;
          end else begin
            do_release = 1'b1;
            state_n    = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start    <= 1'b0;
      tx_data     <= 8'd0;
      ack         <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      burst_cnt   <= 8'd0;
      wait_cnt    <= 4'd0;
      last_flag   <= 1'b0;
      rr_ptr      <= OW'(NUM_REQ - 1);
    end else begin
      tx_start <= do_load;
      ack      <= do_load ? ack_onehot : '0;
      if (do_grant) begin
        owner       <= pick_idx;
        owner_valid <= 1'b1;
        burst_cnt   <= 8'd0;
      end
      if (do_load) begin
        tx_data   <= cur_data;
        last_flag <= req_last[owner];
        burst_cnt <= burst_cnt + 8'd1;
        wait_cnt  <= 4'd0;
      end
      if (wait_inc) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      // The finishing owner becomes lowest priority for the next scan.
      if (do_release) begin
        rr_ptr      <= owner;
        owner       <= '0;
        owner_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] mem [4][32];
  int hd [4] = '{default: 0};
  int tl [4] = '{default: 0};

  int   busy_len = 10;
  int   bcnt = 0;
  logic busy_m = 1'b0;
  logic busy_hold = 1'b0;
  int   fall_cyc = 0;

  int         n_log = 0;
  logic [1:0] log_owner [64];
  logic [7:0] log_data [64];
  logic [3:0] log_ack [64];
  int         log_cyc [64];
  int         ack_bad = 0;

  assign tx_busy = busy_m | busy_hold;

  uart_tx_arbiter #(
    .NUM_REQ   (4),
    .MAX_BURST (16),
    .BUSY_WAIT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .owner       (owner),
    .owner_valid (owner_valid),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: present the head of each byte queue, pop on ack.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) hd[i] <= hd[i] + 1;
    end
  end

  always_comb begin
    req      = '0;
    req_data = '0;
    req_last = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]             = (hd[i] != tl[i]);
      req_data[8*i +: 8] = mem[i][hd[i] % 32][7:0];
      req_last[i]        = mem[i][hd[i] % 32][8];
    end
  end

  // Transmitter: busy for busy_len cycles after each start (never busy when busy_len is 0).
  always @(negedge clk) begin
    if (tx_start && busy_len > 0) begin
      busy_m <= 1'b1;
      bcnt   <= busy_len;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        busy_m   <= 1'b0;
        fall_cyc <= cyc;
      end
    end
  end

  // Transfer log plus ack sanity.
  always @(negedge clk) begin
    if (tx_start && n_log < 64) begin
      log_owner[n_log] <= owner;
      log_data[n_log]  <= tx_data;
      log_ack[n_log]   <= ack;
      log_cyc[n_log]   <= cyc;
      n_log            <= n_log + 1;
    end
    if ((ack != 4'd0 && !tx_start) || !$onehot0(ack)) ack_bad <= ack_bad + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][tl[r] % 32] = {l, d};
    tl[r]++;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && n_log < n; k++) tick();
    chk({tag, "_timeout"}, 32'(n_log >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && (owner_valid || tx_busy); k++) tick();
    chk("idle_timeout", 32'(owner_valid | tx_busy), 32'd0);
  endtask

  task automatic chk_entry(input int i, input int o, input int d, input string tag);
    chk($sformatf("%s_owner%0d", tag, i), 32'(log_owner[i]), o);
    chk($sformatf("%s_data%0d", tag, i), 32'(log_data[i]), d);
    chk($sformatf("%s_ack%0d", tag, i), 32'(log_ack[i]), 32'd1 << o);
  endtask

  initial begin
    int b;
    int c;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 32; j++) mem[i][j] = '0;
    end

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_owner_valid", 32'(owner_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    reset = 1'b0;
    tick();

    // Single requester: 2-cycle latency, release one cycle after busy falls
    busy_len = 10;
    c = cyc;
    push(0, 8'h55, 1'b1);
    wait_log(1, 20, "t1");
    chk_entry(0, 0, 8'h55, "t1");
    chk("t1_latency", 32'(log_cyc[0] - c), 2);
    for (int k = 0; k < 40 && owner_valid; k++) tick();
    chk("t1_owner_valid_drop", 32'(owner_valid), 0);
    chk("t1_release_after_busy", 32'(cyc - fall_cyc), 1);

    // Simultaneous requests from a fresh pointer; requester 0 re-raises after its turn
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    busy_len = 3;
    b = n_log;
    for (int i = 0; i < 4; i++) push(i, 8'hB0 + 8'(i), 1'b1);
    wait_log(b + 1, 20, "t2a");
    push(0, 8'hB4, 1'b1);
    wait_log(b + 5, 200, "t2b");
    chk_entry(b + 0, 0, 8'hB0, "t2");
    chk_entry(b + 1, 1, 8'hB1, "t2");
    chk_entry(b + 2, 2, 8'hB2, "t2");
    chk_entry(b + 3, 3, 8'hB3, "t2");
    chk_entry(b + 4, 0, 8'hB4, "t2");

    // Burst ownership: requester 2 keeps the grant for five bytes while 0 waits
    wait_idle(100);
    b = n_log;
    for (int i = 0; i < 5; i++) push(2, 8'hA0 + 8'(i), i == 4);
    push(0, 8'hC0, 1'b1);
    wait_log(b + 6, 300, "t3");
    for (int i = 0; i < 5; i++) chk_entry(b + i, 2, 8'hA0 + i, "t3");
    chk_entry(b + 5, 0, 8'hC0, "t3");

    // MAX_BURST: requester 1 is cut after 16 bytes, 3 goes, then 1 finishes
    wait_idle(100);
    busy_len = 2;
    b = n_log;
    for (int i = 0; i < 20; i++) push(1, 8'h10 + 8'(i), 1'b0);
    push(3, 8'hD3, 1'b1);
    wait_log(b + 21, 800, "t4");
    for (int i = 0; i < 16; i++) chk_entry(b + i, 1, 8'h10 + i, "t4");
    chk_entry(b + 16, 3, 8'hD3, "t4");
    for (int i = 0; i < 4; i++) chk_entry(b + 17 + i, 1, 8'h20 + i, "t4");

    // Transmitter never busy: BUSY_WAIT timeout gives 6-cycle start spacing
    wait_idle(100);
    busy_len = 0;
    b = n_log;
    push(2, 8'hE0, 1'b0);
    push(2, 8'hE1, 1'b0);
    push(2, 8'hE2, 1'b1);
    wait_log(b + 3, 100, "t5");
    chk_entry(b + 0, 2, 8'hE0, "t5");
    chk_entry(b + 2, 2, 8'hE2, "t5");
    chk("t5_gap1", 32'(log_cyc[b + 1] - log_cyc[b]), 6);
    chk("t5_gap2", 32'(log_cyc[b + 2] - log_cyc[b + 1]), 6);

    // Reset in WAIT_DONE with the frame still on the line
    wait_idle(100);
    busy_len = 10;
    b = n_log;
    push(2, 8'h5A, 1'b1);
    wait_log(b + 1, 20, "t6a");
    repeat (3) tick();
    chk("t6_pre_owner_valid", 32'(owner_valid), 1);
    reset = 1'b1;
    busy_hold = 1'b1;
    #1;
    chk("t6_rst_owner_valid", 32'(owner_valid), 0);
    chk("t6_rst_owner", 32'(owner), 0);
    chk("t6_rst_tx_data", 32'(tx_data), 0);
    chk("t6_rst_ack", 32'(ack), 0);
    chk("t6_rst_tx_start", 32'(tx_start), 0);
    repeat (2) tick();
    reset = 1'b0;
    b = n_log;
    push(0, 8'h6B, 1'b1);
    repeat (12) tick();
    chk("t6_no_start_while_busy", 32'(n_log), 32'(b));
    chk("t6_no_grant_while_busy", 32'(owner_valid), 0);
    busy_hold = 1'b0;
    c = cyc;
    wait_log(b + 1, 20, "t6b");
    chk_entry(b, 0, 8'h6B, "t6");
    chk("t6_latency", 32'(log_cyc[b] - c), 2);

    wait_idle(100);
    chk("ack_only_with_start", 32'(ack_bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
